// File: rtl/instr_buffer_if.sv
// Fetch/dispatch-facing signal bundle of the instruction buffer.
// master = fetch + dispatch side, slave = the buffer itself.
interface instr_buffer_if #(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ENTRY_WIDTH  = 64
);
  localparam int unsigned CntWidth = $clog2(DEPTH) + 1;

  logic                                     flush;
  logic [FETCH_WIDTH-1:0]                   fetch_valid_i;
  logic [FETCH_WIDTH-1:0][ENTRY_WIDTH-1:0]  fetch_data_i;
  logic                                     ib_ready_o;
  logic [DECODE_WIDTH-1:0]                  ib_valid_o;
  logic [DECODE_WIDTH-1:0][ENTRY_WIDTH-1:0] ib_data_o;
  logic [DECODE_WIDTH-1:0]                  ib_accept_i;
  logic [CntWidth-1:0]                      ib_count_o;

  modport master (
    output flush, fetch_valid_i, fetch_data_i, ib_accept_i,
    input  ib_ready_o, ib_valid_o, ib_data_o, ib_count_o
  );

  modport slave (
    input  flush, fetch_valid_i, fetch_data_i, ib_accept_i,
    output ib_ready_o, ib_valid_o, ib_data_o, ib_count_o
  );
endinterface

// File: rtl/instr_buffer.sv
// Instruction buffer: circular FIFO between fetch and decode. Compacts sparse fetch
// bundles on write, presents the oldest DECODE_WIDTH entries, retires a leading-ones prefix.
module instr_buffer #(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ENTRY_WIDTH  = 64
) (
  input  logic          clk,
  input  logic          rst,
  instr_buffer_if.slave bus
);
  localparam int unsigned PtrWidth = $clog2(DEPTH);
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic [ENTRY_WIDTH-1:0] storage_q [DEPTH];
  logic [PtrWidth-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CntWidth-1:0]    count_q, count_d, push_n, pop_n;
  logic [FETCH_WIDTH-1:0][CntWidth-1:0] slot_off;
  logic [DECODE_WIDTH-1:0] head_valid;
  logic                    ready, push_en;

  // Ready depends on registered occupancy only; same-cycle pops are not credited.
  assign ready   = count_q <= CntWidth'(DEPTH - FETCH_WIDTH);
  assign push_en = ready && !bus.flush;

  // Write offset of each valid fetch slot = number of valid slots before it.
  always_comb begin
    push_n   = '0;
    slot_off = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_off[i] = push_n;
      if (bus.fetch_valid_i[i]) push_n = push_n + CntWidth'(1);
    end
  end

  always_comb begin
    head_valid = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      head_valid[i] = count_q > CntWidth'(i);
    end
  end

  always_comb begin
    logic run;
    run   = 1'b1;
    pop_n = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (run && bus.ib_accept_i[i] && head_valid[i]) pop_n = pop_n + CntWidth'(1);
      else run = 1'b0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PtrWidth'(pop_n);
      if (push_en) tail_d = tail_q + PtrWidth'(push_n);
      count_d = count_q - pop_n + (push_en ? push_n : CntWidth'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (bus.fetch_valid_i[i]) begin
          storage_q[tail_q + PtrWidth'(slot_off[i])] <= bus.fetch_data_i[i];
        end
      end
    end
  end

  always_comb begin
    bus.ib_valid_o = head_valid;
    bus.ib_data_o  = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (head_valid[i]) bus.ib_data_o[i] = storage_q[head_q + PtrWidth'(i)];
    end
  end

  assign bus.ib_ready_o = ready;
  assign bus.ib_count_o = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CntWidth'(DEPTH));
      assert (pop_n <= count_q);
      assert (!push_en || (count_q + push_n <= CntWidth'(DEPTH)));
    end
  end
endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: a reference queue holds expected contents; a negedge monitor
// compares the head window, count and ready against it every cycle.
module tb_instr_buffer;
  localparam int unsigned FW = 2, DW = 2, DEPTH = 8, EW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_buffer_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .ENTRY_WIDTH(EW)) bus();

  instr_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .ENTRY_WIDTH(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [EW-1:0] ref_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;
  int  seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int n);
    return 64'h1234_0000_0000_0000 | 64'(n);
  endfunction

  // Monitor: compares DUT head window against the reference queue.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < DW; i++) begin
        if (ref_q.size() > i) begin
          chk("mon_valid", 64'(bus.ib_valid_o[i]), 64'd1);
          chk("mon_data", bus.ib_data_o[i], ref_q[i]);
        end else begin
          chk("mon_valid", 64'(bus.ib_valid_o[i]), 64'd0);
          chk("mon_data_zero", bus.ib_data_o[i], 64'd0);
        end
      end
      chk("mon_count", 64'(bus.ib_count_o), 64'(ref_q.size()));
      chk("mon_ready", 64'(bus.ib_ready_o), 64'(ref_q.size() <= DEPTH - FW));
    end
  end

  // Drive one cycle; expected effect is queued into ref_q at the edge.
  task automatic step(input logic [FW-1:0] fv, input logic [EW-1:0] d0, input logic [EW-1:0] d1,
                      input logic [DW-1:0] acc, input logic fl);
    int sz, pop_n;
    bit rdy;
    bus.fetch_valid_i   = fv;
    bus.fetch_data_i[0] = d0;
    bus.fetch_data_i[1] = d1;
    bus.ib_accept_i     = acc;
    bus.flush           = fl;
    sz    = ref_q.size();
    rdy   = sz <= DEPTH - FW;
    pop_n = 0;
    for (int i = 0; i < DW; i++) begin
      if (acc[i] && sz > i && pop_n == i) pop_n++;
    end
    @(posedge clk);
    if (fl) begin
      ref_q.delete();
    end else begin
      repeat (pop_n) void'(ref_q.pop_front());
      if (rdy) begin
        if (fv[0]) ref_q.push_back(d0);
        if (fv[1]) ref_q.push_back(d1);
      end
    end
    #1;
    bus.fetch_valid_i = '0;
    bus.ib_accept_i   = '0;
    bus.flush         = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] fv_tab [6];
    fv_tab = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01};
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.fetch_valid_i = '0;
    bus.fetch_data_i = '0;
    bus.ib_accept_i = '0;
    #12;
    chk("rst_count", 64'(bus.ib_count_o), 64'd0);
    chk("rst_valid", 64'(bus.ib_valid_o), 64'd0);
    chk("rst_data", 64'(bus.ib_data_o), 64'd0);
    chk("rst_ready", 64'(bus.ib_ready_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // First bundle, visible one cycle later.
    step(2'b11, ent(0), ent(1), 2'b00, 1'b0);
    chk("push_count", 64'(bus.ib_count_o), 64'd2);
    chk("push_valid", 64'(bus.ib_valid_o), 64'd3);
    chk("push_d0", bus.ib_data_o[0], ent(0));
    chk("push_d1", bus.ib_data_o[1], ent(1));

    // Fill to 8; ready drops, 5th bundle ignored.
    step(2'b11, ent(2), ent(3), 2'b00, 1'b0);
    step(2'b11, ent(4), ent(5), 2'b00, 1'b0);
    chk("fill6_ready", 64'(bus.ib_ready_o), 64'd1);
    step(2'b11, ent(6), ent(7), 2'b00, 1'b0);
    chk("full_count", 64'(bus.ib_count_o), 64'd8);
    chk("full_ready", 64'(bus.ib_ready_o), 64'd0);
    step(2'b11, ent(8), ent(9), 2'b00, 1'b0);
    chk("ignored_count", 64'(bus.ib_count_o), 64'd8);

    // Pop 2 while full: offered C,D must not be written.
    step(2'b11, ent(10), ent(11), 2'b11, 1'b0);
    chk("popfull_count", 64'(bus.ib_count_o), 64'd6);
    chk("popfull_ready", 64'(bus.ib_ready_o), 64'd1);
    chk("popfull_d0", bus.ib_data_o[0], ent(2));
    step(2'b11, ent(10), ent(11), 2'b00, 1'b0);
    chk("refill_count", 64'(bus.ib_count_o), 64'd8);

    // Prefix-only accept.
    step(2'b00, '0, '0, 2'b10, 1'b0);
    chk("acc10_count", 64'(bus.ib_count_o), 64'd8);
    chk("acc10_d0", bus.ib_data_o[0], ent(2));
    step(2'b00, '0, '0, 2'b01, 1'b0);
    chk("acc01_count", 64'(bus.ib_count_o), 64'd7);
    chk("acc01_d0", bus.ib_data_o[0], ent(3));
    step(2'b00, '0, '0, 2'b11, 1'b0);
    chk("acc11_count", 64'(bus.ib_count_o), 64'd5);
    chk("acc11_d0", bus.ib_data_o[0], ent(5));

    // Flush overrides simultaneous push and pop.
    step(2'b11, ent(12), ent(13), 2'b11, 1'b1);
    chk("flush_count", 64'(bus.ib_count_o), 64'd0);
    chk("flush_valid", 64'(bus.ib_valid_o), 64'd0);
    chk("flush_ready", 64'(bus.ib_ready_o), 64'd1);

    // Wrap-around with sparse bundles and random accept masks.
    seq = 100;
    for (int c = 0; c < 48; c++) begin
      step(fv_tab[c % 6], ent(seq), ent(seq + 1), 2'($urandom_range(0, 3)), 1'b0);
      seq += 2;
    end
    for (int c = 0; c < 10 && ref_q.size() != 0; c++) step(2'b00, '0, '0, 2'b11, 1'b0);
    chk("drain_count", 64'(bus.ib_count_o), 64'd0);

    // Asynchronous reset between edges.
    step(2'b11, ent(200), ent(201), 2'b00, 1'b0);
    step(2'b11, ent(202), ent(203), 2'b00, 1'b0);
    chk("pre_arst_count", 64'(bus.ib_count_o), 64'd4);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 64'(bus.ib_count_o), 64'd0);
    chk("arst_valid", 64'(bus.ib_valid_o), 64'd0);
    chk("arst_data", 64'(bus.ib_data_o), 64'd0);
    chk("arst_ready", 64'(bus.ib_ready_o), 64'd1);
    ref_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    step(2'b10, ent(300), ent(301), 2'b00, 1'b0);
    chk("post_arst_count", 64'(bus.ib_count_o), 64'd1);
    chk("post_arst_d0", bus.ib_data_o[0], ent(301));
    @(negedge clk);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_buffer.md
# instr_buffer

Decoupling FIFO between instruction fetch and decode/dispatch. Accepts up to FETCH_WIDTH fetched instructions per cycle from the frontend. Presents the oldest DECODE_WIDTH entries in program order to the decoder. Retires them according to the per-slot accept mask returned by dispatch. Absorbs dispatch back-pressure (dual-issue restrictions, block, stall) so fetch can continue until the buffer fills.

## Interface
Parameters:
- FETCH_WIDTH, 2, instructions offered by fetch per cycle
- DECODE_WIDTH, 2, head entries presented to decode per cycle
- DEPTH, 8, entry count; power of two, ≥ 2*FETCH_WIDTH
- ENTRY_WIDTH, 64, opaque payload bits per entry ({pc, instr}; exception bits appended by frontend)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high; clears pointers/count, outputs to reset values
- flush  in  1  pipeline flush; empties buffer on next edge
- fetch_valid_i  in  FETCH_WIDTH  per-slot valid of fetch bundle; any pattern allowed
- fetch_data_i  in  FETCH_WIDTH×ENTRY_WIDTH  payload per slot, slot 0 oldest
- ib_ready_o  out  1  buffer can take a full fetch bundle this cycle
- ib_valid_o  out  DECODE_WIDTH  head slot i holds a valid entry
- ib_data_o  out  DECODE_WIDTH×ENTRY_WIDTH  head payloads, slot 0 = oldest
- ib_accept_i  in  DECODE_WIDTH  per-slot consume mask from dispatch (already gated by stall)
- ib_count_o  out  $clog2(DEPTH)+1  current occupancy (debug/perf)

## Operation
- State: storage[DEPTH], head, tail ($clog2(DEPTH) bits, wrap modulo DEPTH), count ($clog2(DEPTH)+1 bits, 0..DEPTH).
- ib_ready_o = (count ≤ DEPTH − FETCH_WIDTH), from registered count only. It does not credit same-cycle pops.
- Push: when ib_ready_o && !flush, valid fetch slots are compacted in slot order and written at tail, tail+1, … (mod DEPTH). push_n = popcount(fetch_valid_i). When !ib_ready_o, the fetch bundle is ignored; fetch must hold and re-offer it.
- Pop: accept is honoured only as a prefix from slot 0. pop_n = number of leading ones of (ib_accept_i & ib_valid_o). Example: mask 2'b10 pops 0; 2'b11 with only slot 0 valid pops 1.
- Output: ib_valid_o[i] = (count > i). ib_data_o[i] = storage[(head+i) mod DEPTH] when valid, else all zeros. Output is a purely combinational read of registered state, with no path from fetch or accept inputs.
- Update: head += pop_n; tail += push_n; count += push_n − pop_n. Simultaneous push and pop in one cycle is legal.
- Flush: head = tail = count = 0 at the next edge. Same-cycle push and pop are discarded. Flush overrides all.
- Storage contents are not reset. Only pointers and count are.

## Timing
- Reset values (asynchronous): head=0, tail=0, count=0, ib_valid_o=0, ib_data_o=0, ib_ready_o=1, ib_count_o=0.
- Latency: an entry pushed at edge N is visible on ib_valid_o/ib_data_o after edge N (fetch-to-decode minimum 1 cycle). No same-cycle bypass when empty.
- Accepted entries disappear after the edge where ib_accept_i is sampled. The next entries shift into slot 0/1 in the same cycle.
- Full: count > DEPTH − FETCH_WIDTH drops ib_ready_o, even if dispatch pops that cycle. Ready returns the cycle after count falls.
- Wrap-around: pointer increments wrap modulo DEPTH. A head read spanning index DEPTH−1→0 returns entries in correct order.
- Empty: count=0 ⇒ all ib_valid_o=0, any accept ignored, pop_n=0.
- Count never exceeds DEPTH, never underflows. Violation is an assertion failure in simulation.
- Reset asserted mid-operation immediately clears state regardless of clk. Deassertion is synchronous to the design, so the first push occurs on the first edge after rst falls.

## Test plan
- Reset, then push {A,B} with fetch_valid_i=11 and accept=00 -> next cycle ib_valid_o=11, data={B,A}, count=2.
- Push 4 bundles of 2 with accept=00 (DEPTH=8) -> ib_ready_o falls once count=7..8. A 5th bundle is ignored. count stays 8.
- count=8, accept=11 for one cycle while fetch offers C,D -> count=6, C,D not written. Next cycle ready=1, push succeeds, count=8 minus pops.
- Accept pattern 2'b10 with two valid heads -> nothing popped. 2'b01 -> one pop, old slot 1 moves to slot 0.
- Run head/tail past index 7 with mixed fetch_valid_i (01,10,11) and random prefix accepts -> output order matches a reference queue model, no loss or duplication.
- Flush asserted with count=5, simultaneous push 11 and accept 11 -> next cycle count=0, ib_valid_o=00, ib_ready_o=1.
- Assert rst asynchronously mid-stream -> outputs zero without a clock edge.
